// File: rtl/iso_rx_char_pkg.sv
// Shared types and constants for the ISO7816-3 character receiver.
// Also intended for the future transmitter in the same slice.
package iso_rx_char_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_GUARD,
        ST_ERRSIG,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam logic CONV_DIRECT  = 1'b0;
    localparam logic CONV_INVERSE = 1'b1;

    localparam int CHAR_DATA_BITS = 8;

    localparam int TICK_PARITY  = 9;
    localparam int TICK_GUARD   = 10;
    localparam int TICK_ERR_END = 11;

    // Direct fills LSB-first, inverse fills MSB-first.
    function automatic logic [7:0] shift_in(
        input logic [7:0] sh,
        input logic       b,
        input logic       conv
    );
        return (conv == CONV_INVERSE) ? {sh[6:0], b} : {b, sh[7:1]};
    endfunction

endpackage

// File: rtl/iso_rx_char_if.sv
// Line/ETU/protocol-side signal bundle of the character receiver.
// slave = receiver side, master = driver of the receiver inputs.
interface iso_rx_char_if;

    logic       enable;
    logic       inverseConv;
    logic       errSigEnable;
    logic       ioIn;
    logic       sampleTick;
    logic       etuClear;
    logic       ioDriveLow;
    logic [7:0] data;
    logic       dataValid;
    logic       parityError;
    logic       frameError;
    logic       busy;

    modport slave (
        input  enable,
        input  inverseConv,
        input  errSigEnable,
        input  ioIn,
        input  sampleTick,
        output etuClear,
        output ioDriveLow,
        output data,
        output dataValid,
        output parityError,
        output frameError,
        output busy
    );

    modport master (
        output enable,
        output inverseConv,
        output errSigEnable,
        output ioIn,
        output sampleTick,
        input  etuClear,
        input  ioDriveLow,
        input  data,
        input  dataValid,
        input  parityError,
        input  frameError,
        input  busy
    );

endinterface

// File: rtl/iso_rx_char_io_sync.sv
// Multi-stage synchroniser for the asynchronous I/O line.
// Resets to 1 so an idle-high line never looks like a start edge.
module io_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/iso_rx_char.sv
// ISO7816-3 character receiver: start detect, 8 data + parity,
// convention handling, T=0 error signal and guard-time checks.
module iso_rx_char #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    iso_rx_char_if.slave  bus
);

    import iso_rx_char_pkg::*;

    localparam logic [2:0] BIT_LAST = 3'(CHAR_DATA_BITS - 1);

    logic w_io;
    logic w_fall;
    logic w_tick;
    logic w_bit;

    rx_state_t  r_state;
    logic       r_io_d;
    logic       r_conv;
    logic       r_par;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_etu_clear;
    logic       r_drive;
    logic       r_valid;
    logic       r_parity_error;
    logic       r_frame;

    io_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.ioIn),
        .o_q   (w_io)
    );

    assign w_fall = r_io_d & ~w_io;
    // A tick landing with the counter restart belongs to the old frame.
    assign w_tick = bus.sampleTick & ~r_etu_clear;
    assign w_bit  = (r_conv == CONV_INVERSE) ? ~w_io : w_io;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_io_d         <= 1'b1;
            r_conv         <= CONV_DIRECT;
            r_par          <= 1'b0;
            r_bit_cnt      <= 3'd0;
            r_shift        <= 8'h00;
            r_data         <= 8'h00;
            r_etu_clear    <= 1'b0;
            r_drive        <= 1'b0;
            r_valid        <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame        <= 1'b0;
        end else begin
            r_io_d      <= w_io;
            r_etu_clear <= 1'b0;
            r_valid     <= 1'b0;
            r_frame     <= 1'b0;
            if (!bus.enable) begin
                r_state <= ST_IDLE;
                r_drive <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_fall) begin
                            r_etu_clear <= 1'b1;
                            r_conv      <= bus.inverseConv;
                            r_bit_cnt   <= 3'd0;
                            r_par       <= 1'b0;
                            r_state     <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (w_tick) begin
                            r_state <= w_io ? ST_IDLE : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_tick) begin
                            r_shift   <= shift_in(r_shift, w_bit, r_conv);
                            r_par     <= r_par ^ w_bit;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_tick) begin
                            r_data         <= r_shift;
                            r_valid        <= 1'b1;
                            r_parity_error <= r_par ^ w_bit;
                            r_state        <= ST_GUARD;
                        end
                    end
                    ST_GUARD: begin
                        if (w_tick) begin
                            if (r_parity_error && bus.errSigEnable) begin
                                r_drive <= 1'b1;
                                r_state <= ST_ERRSIG;
                            end else begin
                                r_frame <= ~w_io;
                                r_state <= ST_WAIT_HIGH;
                            end
                        end
                    end
                    ST_ERRSIG: begin
                        if (w_tick) begin
                            r_drive <= 1'b0;
                            r_state <= ST_WAIT_HIGH;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (w_io) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.etuClear    = r_etu_clear;
    assign bus.ioDriveLow  = r_drive;
    assign bus.data        = r_data;
    assign bus.dataValid   = r_valid;
    assign bus.parityError = r_parity_error;
    assign bus.frameError  = r_frame;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_iso_rx_char.sv
// Scoreboard bench for iso_rx_char: card line model, ETU counter
// model, and a monitor comparing delivered bytes with a line decoder.
module tb_iso_rx_char;

    import iso_rx_char_pkg::*;

    localparam int ETU  = 16;
    localparam int HALF = 6;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx = 1'b1;

    iso_rx_char_if bus ();

    // Open-drain wired-AND of card transmitter and receiver error drive.
    assign bus.ioIn = tx & ~bus.ioDriveLow;

    iso_rx_char #(
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t9 = -100;
    int         n_clr = 0;
    int         n_drive = 0;
    int         n_fe = 0;
    int         n_valid = 0;
    int         ph = 0;
    bit         run = 1'b0;
    logic [7:0] last_d = 8'h00;

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line bit i in time is data bit i (direct) or 7-i (inverse);
    // inverse also means low level = logic 1. Parity must be even.
    function automatic exp_t decode(
        input logic [8:0] lvl,
        input logic       inv
    );
        exp_t       r;
        logic [8:0] lg;
        lg = inv ? ~lvl : lvl;
        r.d = 8'h00;
        for (int i = 0; i < CHAR_DATA_BITS; i++) begin
            r.d[inv ? 7 - i : i] = lg[i];
        end
        r.p = ^lg;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ETU counter: first tick mid start bit, then one per ETU.
    initial begin
        bus.sampleTick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.etuClear) begin
                run = 1'b1;
                ph = 0;
                bus.sampleTick = 1'b0;
            end else if (run) begin
                ph++;
                bus.sampleTick = (ph >= HALF) && ((ph - HALF) % ETU == 0);
                if (ph == HALF + 9 * ETU) begin
                    t9 = cyc;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.etuClear) n_clr++;
        if (bus.ioDriveLow) n_drive++;
        if (bus.frameError) n_fe++;
        if (bus.dataValid) begin
            n_valid++;
            chk("dv_latency", cyc, t9 + 1);
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_dv: got %0h expected none",
                         bus.data);
            end else begin
                mon_e = q.pop_front();
                chk("data", bus.data, mon_e.d);
                chk("parity_err", bus.parityError, mon_e.p);
            end
        end
    end

    task automatic send_line(
        input logic [8:0] lvl,
        input logic       inv,
        input logic       es,
        input logic       glow,
        input logic       push,
        input exp_t       ex,
        input logic       post
    );
        bus.inverseConv = inv;
        bus.errSigEnable = es;
        n_clr = 0;
        n_drive = 0;
        n_fe = 0;
        n_valid = 0;
        if (push) q.push_back(ex);
        tx = 1'b0;
        repeat (ETU) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            tx = lvl[i];
            repeat (ETU) @(negedge clk);
        end
        tx = ~glow;
        repeat (glow ? 3 * ETU : ETU) @(negedge clk);
        tx = 1'b1;
        repeat (3 * ETU) @(negedge clk);
        if (post) begin
            chk("etu_clear_cnt", n_clr, 1);
            chk("dv_cnt", n_valid, {31'd0, push});
            chk("drive_cycles", n_drive,
                (push && ex.p && es) ? ETU : 0);
            chk("frame_err_cnt", n_fe,
                (push && glow && !(ex.p && es)) ? 1 : 0);
            chk("busy_idle", bus.busy, 0);
        end
        if (push) last_d = ex.d;
    endtask

    logic [8:0] r_lvl;
    logic       r_inv;
    logic       r_es;
    logic       r_glow;

    initial begin
        bus.enable = 1'b0;
        bus.inverseConv = 1'b0;
        bus.errSigEnable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_dv", bus.dataValid, 0);
        chk("rst_drive", bus.ioDriveLow, 0);
        chk("rst_clr", bus.etuClear, 0);
        chk("rst_perr", bus.parityError, 0);
        chk("rst_ferr", bus.frameError, 0);
        reset = 1'b0;
        bus.enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        send_line(9'h13B, 1'b0, 1'b1, 1'b0, 1'b1,
                  '{d: 8'h3B, p: 1'b0}, 1'b1);
        send_line(9'h103, 1'b1, 1'b1, 1'b0, 1'b1,
                  '{d: 8'h3F, p: 1'b0}, 1'b1);
        send_line(9'h103, 1'b0, 1'b0, 1'b0, 1'b1,
                  '{d: 8'h03, p: 1'b1}, 1'b1);
        send_line(9'h1A5, 1'b0, 1'b1, 1'b0, 1'b1,
                  '{d: 8'hA5, p: 1'b1}, 1'b1);
        send_line(9'h1A5, 1'b0, 1'b0, 1'b0, 1'b1,
                  '{d: 8'hA5, p: 1'b1}, 1'b1);

        n_clr = 0;
        n_valid = 0;
        tx = 1'b0;
        repeat (3) @(negedge clk);
        tx = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_clr", n_clr, 1);
        chk("glitch_dv", n_valid, 0);
        chk("glitch_busy", bus.busy, 0);

        send_line(9'h055, 1'b0, 1'b1, 1'b0, 1'b1,
                  '{d: 8'h55, p: 1'b0}, 1'b1);
        send_line(9'h13B, 1'b0, 1'b1, 1'b1, 1'b1,
                  '{d: 8'h3B, p: 1'b0}, 1'b1);

        fork
            send_line(9'h05A, 1'b0, 1'b1, 1'b0, 1'b0,
                      '{d: 8'h00, p: 1'b0}, 1'b1);
            begin
                repeat (89) @(negedge clk);
                bus.enable = 1'b0;
                @(negedge clk);
                chk("en_drop_busy", bus.busy, 0);
            end
        join
        chk("en_drop_data", bus.data, last_d);
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            r_lvl = 9'($urandom);
            r_inv = 1'($urandom);
            r_es = 1'($urandom);
            r_glow = ($urandom_range(0, 3) == 0);
            send_line(r_lvl, r_inv, r_es, r_glow, 1'b1,
                      decode(r_lvl, r_inv), 1'b1);
        end

        fork
            send_line(9'h1A5, 1'b0, 1'b1, 1'b0, 1'b1,
                      '{d: 8'hA5, p: 1'b1}, 1'b0);
            begin
                repeat (178) @(negedge clk);
                chk("errsig_active", bus.ioDriveLow, 1);
                reset = 1'b1;
                #1;
                chk("arst_drive", bus.ioDriveLow, 0);
                chk("arst_busy", bus.busy, 0);
                chk("arst_data", bus.data, 0);
                chk("arst_perr", bus.parityError, 0);
                chk("arst_dv", bus.dataValid, 0);
                chk("arst_clr", bus.etuClear, 0);
                chk("arst_ferr", bus.frameError, 0);
                @(negedge clk);
                reset = 1'b0;
            end
        join
        last_d = 8'h00;

        send_line(9'h055, 1'b0, 1'b1, 1'b0, 1'b1,
                  '{d: 8'h55, p: 1'b0}, 1'b1);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
